operand_feeder: RTL

- Write side of the engine operand FIFOs. Accepts one 16-bit DMA word stream and splits it into per-port data FIFOs, per-port weight FIFOs and per-port bias registers, as selected by op_type.
- The engine reads these FIFOs with rd_en and a registered dout.
- Sits between the DMA read channel and the conv engine.

---
 rtl/operand_feeder_if.sv | 47 ++++
 rtl/operand_feeder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/operand_feeder_if.sv
// Stream and engine-read bundle of the operand feeder: DMA word stream in,
// four operand FIFO read ports plus per-port bias out.
interface operand_feeder_if #(
    parameter int DW = 16
);
    logic          dma_valid;
    logic [DW-1:0] dma_data;
    logic          dma_ready;

    logic          p0_data_fifo_rd_en;
    logic          p0_weight_fifo_rd_en;
    logic          p1_data_fifo_rd_en;
    logic          p1_weight_fifo_rd_en;

    logic [DW-1:0] data_0;
    logic [DW-1:0] weight_0;
    logic [DW-1:0] data_1;
    logic [DW-1:0] weight_1;
    logic [DW-1:0] bias_0;
    logic [DW-1:0] bias_1;

    logic          p0_data_empty;
    logic          p0_weight_empty;
    logic          p1_data_empty;
    logic          p1_weight_empty;
    logic          underflow;

    modport master (
        output dma_valid, dma_data,
        output p0_data_fifo_rd_en, p0_weight_fifo_rd_en,
        output p1_data_fifo_rd_en, p1_weight_fifo_rd_en,
        input  dma_ready,
        input  data_0, weight_0, data_1, weight_1, bias_0, bias_1,
        input  p0_data_empty, p0_weight_empty, p1_data_empty, p1_weight_empty,
        input  underflow
    );

    modport slave (
        input  dma_valid, dma_data,
        input  p0_data_fifo_rd_en, p0_weight_fifo_rd_en,
        input  p1_data_fifo_rd_en, p1_weight_fifo_rd_en,
        output dma_ready,
        output data_0, weight_0, data_1, weight_1, bias_0, bias_1,
        output p0_data_empty, p0_weight_empty, p1_data_empty, p1_weight_empty,
        output underflow
    );
endinterface

// File: rtl/operand_feeder.sv
// Splits the DMA word stream (bias, BURST_LEN data, BURST_LEN weights per burst)
// into per-port operand FIFOs and bias registers for the conv engine.
module operand_feeder #(
    parameter int DW        = 16,
    parameter int DEPTH     = 32,
    parameter int AW        = 5,
    parameter int BURST_LEN = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [2:0]  op_type_i,
    input  logic [15:0] burst_num_i,
    output logic        busy_o,
    output logic        done_o,
    operand_feeder_if.slave bus
);
    localparam logic [2:0]  OP_CONV1  = 3'd1;
    localparam logic [2:0]  OP_CONV3  = 3'd2;
    localparam logic [2:0]  OP_CONVP  = 3'd3;
    localparam logic [4:0]  LAST_BEAT = 5'(BURST_LEN - 1);
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_BIAS, S_DATA, S_WEIGHT, S_DONE} state_t;

    state_t          state_q;
    logic [2:0]      op_q;
    logic [15:0]     remain_q;
    logic            port_q;
    logic [4:0]      beat_q;
    logic            busy_q;
    logic            done_q;
    logic [DW-1:0]   bias0_q;
    logic [DW-1:0]   bias1_q;
    logic            underflow_q;

    // FIFO index: {port, 0} = data, {port, 1} = weight
    logic [3:0]      rd_en;
    logic [3:0]      wr_en;
    logic [3:0]      empty;
    logic [3:0]      full;
    logic [DW-1:0]   dout [4];
    logic [1:0]      data_idx;
    logic [1:0]      wt_idx;
    logic            ready;
    logic            accept;

    assign rd_en    = {bus.p1_weight_fifo_rd_en, bus.p1_data_fifo_rd_en,
                       bus.p0_weight_fifo_rd_en, bus.p0_data_fifo_rd_en};
    assign data_idx = {port_q, 1'b0};
    assign wt_idx   = {port_q, 1'b1};
    assign accept   = bus.dma_valid & ready;

    // A new burst may only start once the previous burst on that port is drained.
    always_comb begin
        ready = 1'b0;
        case (state_q)
            S_BIAS:   ready = empty[data_idx] & empty[wt_idx];
            S_DATA:   ready = ~full[data_idx];
            S_WEIGHT: ready = ~full[wt_idx];
            default:  ready = 1'b0;
        endcase
    end

    always_comb begin
        wr_en = '0;
        if (accept && state_q == S_DATA)   wr_en[data_idx] = 1'b1;
        if (accept && state_q == S_WEIGHT) wr_en[wt_idx]   = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            remain_q <= '0;
            port_q   <= 1'b0;
            beat_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bias0_q  <= '0;
            bias1_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        op_q     <= op_type_i;
                        remain_q <= burst_num_i;
                        port_q   <= (op_type_i == OP_CONV1);
                        beat_q   <= '0;
                        busy_q   <= 1'b1;
                        if (burst_num_i == 16'd0 ||
                            !(op_type_i == OP_CONV1 || op_type_i == OP_CONV3 ||
                              op_type_i == OP_CONVP))
                            state_q <= S_DONE;
                        else
                            state_q <= S_BIAS;
                    end
                end
                S_BIAS: begin
                    if (accept) begin
                        if (port_q) bias1_q <= bus.dma_data;
                        else        bias0_q <= bus.dma_data;
                        beat_q  <= '0;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        if (beat_q == LAST_BEAT) begin
                            beat_q  <= '0;
                            state_q <= S_WEIGHT;
                        end else begin
                            beat_q <= beat_q + 5'd1;
                        end
                    end
                end
                S_WEIGHT: begin
                    if (accept) begin
                        if (beat_q == LAST_BEAT) begin
                            beat_q   <= '0;
                            remain_q <= remain_q - 16'd1;
                            if (op_q == OP_CONVP) port_q <= ~port_q;
                            state_q  <= (remain_q == 16'd1) ? S_DONE : S_BIAS;
                        end else begin
                            beat_q <= beat_q + 5'd1;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fifo
            logic [DW-1:0] mem_q [DEPTH];
            logic [AW:0]   wr_ptr_q;
            logic [AW:0]   rd_ptr_q;
            logic [DW-1:0] dout_q;
            logic          rd_ok;

            assign empty[gi] = (wr_ptr_q == rd_ptr_q);
            assign full[gi]  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                               (wr_ptr_q[AW] != rd_ptr_q[AW]);
            assign rd_ok     = rd_en[gi] & ~empty[gi];
            assign dout[gi]  = dout_q;

            always_ff @(posedge clk) begin
                if (wr_en[gi]) mem_q[wr_ptr_q[AW-1:0]] <= bus.dma_data;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    dout_q   <= '0;
                end else begin
                    if (wr_en[gi]) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                    if (rd_ok) begin
                        dout_q   <= mem_q[rd_ptr_q[AW-1:0]];
                        rd_ptr_q <= rd_ptr_q + PTR_ONE;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                underflow_q <= 1'b0;
        else if (|(rd_en & empty)) underflow_q <= 1'b1;
    end

    assign busy_o              = busy_q;
    assign done_o              = done_q;
    assign bus.dma_ready       = ready;
    assign bus.data_0          = dout[0];
    assign bus.weight_0        = dout[1];
    assign bus.data_1          = dout[2];
    assign bus.weight_1        = dout[3];
    assign bus.bias_0          = bias0_q;
    assign bus.bias_1          = bias1_q;
    assign bus.p0_data_empty   = empty[0];
    assign bus.p0_weight_empty = empty[1];
    assign bus.p1_data_empty   = empty[2];
    assign bus.p1_weight_empty = empty[3];
    assign bus.underflow       = underflow_q;
endmodule
